// File: rtl/video_hist_pp.sv
// Frame-synchronous pixel histogram with ping-pong banks: one bank accumulates
// the current frame while software reads the completed frame from the other.
module video_hist_pp #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BIN_BITS    = 6,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned VS_ACT_HIGH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode_i,
    input  logic [DATA_W-1:0]   red_i,
    input  logic [DATA_W-1:0]   green_i,
    input  logic [DATA_W-1:0]   blue_i,
    input  logic                dv_i,
    input  logic                vs_i,
    input  logic                rd_strobe_i,
    input  logic [BIN_BITS-1:0] rd_addr_i,
    output logic                rd_ack_o,
    output logic [CNT_W-1:0]    hist_bin_o,
    output logic                frame_done_o,
    output logic                bank_valid_o,
    output logic                sat_o,
    output logic                lost_o
);

    localparam int unsigned NBINS = 1 << BIN_BITS;
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned BIN_SHIFT = DATA_W - BIN_BITS;
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_vs_q;
    logic                w_vs_pol;
    logic                w_fs;
    logic                w_start;
    logic                w_swap;
    logic                w_clr_en;
    logic                w_pix_en;
    logic                w_lost;

    logic [1:0]          r_mode;
    logic                r_wr_bank;
    logic [BIN_BITS-1:0] r_clr_cnt;

    logic [SUM_W-1:0]    w_luma_sum;
    logic [DATA_W-1:0]   w_luma;
    logic [DATA_W-1:0]   w_val;
    logic [BIN_BITS-1:0] w_bin;

    logic                r_s1_vld;
    logic [BIN_BITS-1:0] r_s1_bin;
    logic                r_s1_bank;
    logic                r_s2_vld;
    logic [BIN_BITS-1:0] r_s2_bin;
    logic                r_s2_bank;

    logic                r_lw_vld;
    logic                r_lw_bank;
    logic [BIN_BITS-1:0] r_lw_bin;
    logic [CNT_W-1:0]    r_lw_data;

    logic [CNT_W-1:0]    w_q_s2;
    logic                w_fwd;
    logic [CNT_W-1:0]    w_base;
    logic                w_at_max;
    logic [CNT_W-1:0]    w_inc;
    logic                w_sat_hit;

    logic [CNT_W-1:0]    r_mem0 [NBINS];
    logic [CNT_W-1:0]    r_mem1 [NBINS];
    logic [CNT_W-1:0]    r_q0;
    logic [CNT_W-1:0]    r_q1;
    logic [BIN_BITS-1:0] w_raddr0;
    logic [BIN_BITS-1:0] w_raddr1;
    logic                w_clr0;
    logic                w_clr1;
    logic                w_we0;
    logic                w_we1;
    logic [BIN_BITS-1:0] w_waddr0;
    logic [BIN_BITS-1:0] w_waddr1;
    logic [CNT_W-1:0]    w_wdata0;
    logic [CNT_W-1:0]    w_wdata1;

    logic                w_rd_accept;
    logic                r_rp_pend;
    logic                r_rp_bank;
    logic [BIN_BITS-1:0] r_rp_addr;
    logic                r_rp_zero;
    logic [CNT_W-1:0]    w_rp_q;
    logic                w_rp_fwd;

    logic                r_ack;
    logic [CNT_W-1:0]    r_hist;
    logic                r_frame_done;
    logic                r_bank_valid;
    logic                r_sat;
    logic                r_sat_flag;
    logic                r_lost;

    // Frame start: polarity-corrected vs compared against its registered copy
    assign w_vs_pol = (VS_ACT_HIGH != 0) ? vs_i : ~vs_i;
    assign w_fs     = w_vs_pol & ~r_vs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_swap      = 1'b0;
        w_clr_en    = 1'b0;
        w_pix_en    = 1'b0;
        w_lost      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fs) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                w_lost   = dv_i;
                if (r_clr_cnt == LAST_BIN) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_fs) begin
                    w_start     = 1'b1;
                    w_swap      = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_pix_en = dv_i;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_q       <= 1'b1;
            r_mode       <= 2'd0;
            r_wr_bank    <= 1'b0;
            r_clr_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_bank_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_sat_flag   <= 1'b0;
            r_lost       <= 1'b0;
        end else begin
            r_vs_q       <= w_vs_pol;
            r_frame_done <= w_swap;
            if (w_start) begin
                r_mode <= mode_i;
            end
            if (w_clr_en) begin
                r_clr_cnt <= r_clr_cnt + BIN_BITS'(1);
            end
            if (w_lost) begin
                r_lost <= 1'b1;
            end
            // Drain writes tagged with the old bank still report into sat_o
            if (w_swap) begin
                r_wr_bank    <= ~r_wr_bank;
                r_bank_valid <= 1'b1;
                r_sat        <= r_sat_flag | w_sat_hit;
                r_sat_flag   <= 1'b0;
            end else if (w_sat_hit) begin
                if (r_s2_bank == r_wr_bank) begin
                    r_sat_flag <= 1'b1;
                end else begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign w_luma_sum = SUM_W'(red_i) + (SUM_W'(green_i) << 1) + SUM_W'(blue_i);
    assign w_luma     = DATA_W'(w_luma_sum >> 2);

    always_comb begin
        w_val = w_luma;
        case (r_mode)
            2'd0:    w_val = red_i;
            2'd1:    w_val = green_i;
            2'd2:    w_val = blue_i;
            default: w_val = w_luma;
        endcase
    end

    assign w_bin = BIN_BITS'(w_val >> BIN_SHIFT);

    // Pipeline: stage 1 holds the bin, stage 2 waits on the RAM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_bin  <= '0;
            r_s1_bank <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_bin  <= '0;
            r_s2_bank <= 1'b0;
            r_lw_vld  <= 1'b0;
            r_lw_bank <= 1'b0;
            r_lw_bin  <= '0;
            r_lw_data <= '0;
        end else begin
            r_s1_vld  <= w_pix_en;
            r_s1_bin  <= w_bin;
            r_s1_bank <= r_wr_bank;
            r_s2_vld  <= r_s1_vld;
            r_s2_bin  <= r_s1_bin;
            r_s2_bank <= r_s1_bank;
            r_lw_vld  <= r_s2_vld;
            r_lw_bank <= r_s2_bank;
            r_lw_bin  <= r_s2_bin;
            r_lw_data <= w_inc;
        end
    end

    // The write that lands on the same edge as a RAM read is seen via r_lw
    assign w_q_s2    = r_s2_bank ? r_q1 : r_q0;
    assign w_fwd     = r_lw_vld && (r_lw_bank == r_s2_bank) && (r_lw_bin == r_s2_bin);
    assign w_base    = w_fwd ? r_lw_data : w_q_s2;
    assign w_at_max  = (w_base == CNT_MAX);
    assign w_inc     = w_at_max ? w_base : w_base + CNT_W'(1);
    assign w_sat_hit = r_s2_vld && w_at_max;

    // Each bank: the write bank serves the pipeline, the read bank serves software
    assign w_raddr0 = (r_wr_bank == 1'b0) ? r_s1_bin : rd_addr_i;
    assign w_raddr1 = (r_wr_bank == 1'b1) ? r_s1_bin : rd_addr_i;
    assign w_clr0   = w_clr_en && (r_wr_bank == 1'b0);
    assign w_clr1   = w_clr_en && (r_wr_bank == 1'b1);
    assign w_we0    = w_clr0 || (r_s2_vld && (r_s2_bank == 1'b0));
    assign w_we1    = w_clr1 || (r_s2_vld && (r_s2_bank == 1'b1));
    assign w_waddr0 = w_clr0 ? r_clr_cnt : r_s2_bin;
    assign w_waddr1 = w_clr1 ? r_clr_cnt : r_s2_bin;
    assign w_wdata0 = w_clr0 ? '0 : w_inc;
    assign w_wdata1 = w_clr1 ? '0 : w_inc;

    always_ff @(posedge clk) begin
        if (w_we0) begin
            r_mem0[w_waddr0] <= w_wdata0;
        end
        r_q0 <= r_mem0[w_raddr0];
    end

    always_ff @(posedge clk) begin
        if (w_we1) begin
            r_mem1[w_waddr1] <= w_wdata1;
        end
        r_q1 <= r_mem1[w_raddr1];
    end

    // Readout: bank and address captured at the strobe, data registered a cycle later
    assign w_rd_accept = rd_strobe_i && !r_rp_pend;
    assign w_rp_q      = r_rp_bank ? r_q1 : r_q0;
    assign w_rp_fwd    = r_lw_vld && (r_lw_bank == r_rp_bank) && (r_lw_bin == r_rp_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rp_pend <= 1'b0;
            r_rp_bank <= 1'b0;
            r_rp_addr <= '0;
            r_rp_zero <= 1'b0;
            r_ack     <= 1'b0;
            r_hist    <= '0;
        end else begin
            r_rp_pend <= w_rd_accept;
            r_ack     <= r_rp_pend;
            if (w_rd_accept) begin
                r_rp_bank <= ~r_wr_bank;
                r_rp_addr <= rd_addr_i;
                r_rp_zero <= ~r_bank_valid;
            end
            if (r_rp_pend) begin
                r_hist <= r_rp_zero ? '0 : (w_rp_fwd ? r_lw_data : w_rp_q);
            end
        end
    end

    assign rd_ack_o     = r_ack;
    assign hist_bin_o   = r_hist;
    assign frame_done_o = r_frame_done;
    assign bank_valid_o = r_bank_valid;
    assign sat_o        = r_sat;
    assign lost_o       = r_lost;

endmodule

// File: tb/tb_video_hist_pp.sv
// Directed bench for video_hist_pp: a default build and a CNT_W=4 build share stimulus.
module tb_video_hist_pp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        dv;
    logic        vs;
    logic        rd_strobe;
    logic [5:0]  rd_addr;

    logic        ack;
    logic [15:0] hist;
    logic        fd;
    logic        bv;
    logic        sat;
    logic        lost;

    logic        ack4;
    logic [3:0]  hist4;
    logic        fd4;
    logic        bv4;
    logic        sat4;
    logic        lost4;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd4_cnt = 0;

    video_hist_pp u_dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode),
        .red_i(red), .green_i(green), .blue_i(blue),
        .dv_i(dv), .vs_i(vs), .rd_strobe_i(rd_strobe), .rd_addr_i(rd_addr),
        .rd_ack_o(ack), .hist_bin_o(hist), .frame_done_o(fd),
        .bank_valid_o(bv), .sat_o(sat), .lost_o(lost)
    );

    video_hist_pp #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode),
        .red_i(red), .green_i(green), .blue_i(blue),
        .dv_i(dv), .vs_i(vs), .rd_strobe_i(rd_strobe), .rd_addr_i(rd_addr),
        .rd_ack_o(ack4), .hist_bin_o(hist4), .frame_done_o(fd4),
        .bank_valid_o(bv4), .sat_o(sat4), .lost_o(lost4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fd === 1'b1)  fd_cnt  <= fd_cnt + 1;
        if (fd4 === 1'b1) fd4_cnt <= fd4_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [5:0] a);
        rd_addr   = a;
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        check("ack_at_strobe_plus1", 32'(ack), 32'd0);
        tick();
        check("ack_at_strobe_plus2", 32'(ack), 32'd1);
        check("ack4_at_strobe_plus2", 32'(ack4), 32'd1);
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        red   = r;
        green = g;
        blue  = b;
        dv    = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; red = '0; green = '0; blue = '0;
        dv = 1'b0; vs = 1'b0; rd_strobe = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_hist", 32'(hist), 32'd0);
        check("rst_fd", 32'(fd), 32'd0);
        check("rst_bv", 32'(bv), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read before any frame: zero with normal ack timing
        do_read(6'd5);
        check("pre_frame_hist", 32'(hist), 32'd0);
        check("pre_frame_bv", 32'(bv), 32'd0);

        // First vs: IDLE -> CLEAR, no frame_done
        vs = 1'b1; tick(); vs = 1'b0; tick();
        repeat (70) tick();
        check("no_fd_first_vs", 32'(fd_cnt), 32'd0);

        // Frame 1: 100 red=0x40 pixels (bin 16); mode change mid-frame must not apply
        for (int i = 0; i < 100; i++) begin
            if (i == 50) mode = 2'd1;
            pix(8'h40, 8'h00, 8'h00);
        end
        dv = 1'b0;
        mode = 2'd3;
        vs = 1'b1;
        tick();
        check("fd_pulse_f1", 32'(fd), 32'd1);
        vs = 1'b0;
        tick();
        check("fd_one_cycle", 32'(fd), 32'd0);
        check("bv_after_swap", 32'(bv), 32'd1);
        // Pixels during CLEAR: flagged lost, never counted (bin 31 in luma mode)
        red = 8'hFF; green = 8'h00; blue = 8'hFF; dv = 1'b1;
        tick(); tick();
        dv = 1'b0;
        tick();
        check("lost_set", 32'(lost), 32'd1);
        check("lost4_set", 32'(lost4), 32'd1);
        check("sat_f1", 32'(sat), 32'd0);
        check("sat4_f1", 32'(sat4), 32'd1);
        check("fd_cnt_f1", 32'(fd_cnt), 32'd1);
        do_read(6'd16);
        check("f1_bin16", 32'(hist), 32'd100);
        check("f1_bin16_c4", 32'(hist4), 32'd15);
        do_read(6'd17);
        check("f1_bin17", 32'(hist), 32'd0);
        repeat (70) tick();

        // Frame 2: luma mode, bins 31/31/2/31 back-to-back
        for (int i = 0; i < 100; i++) begin
            pix(8'hFF, 8'h00, 8'hFF);
            pix(8'hFF, 8'h00, 8'hFF);
            pix(8'h08, 8'h08, 8'h08);
            pix(8'hFF, 8'h00, 8'hFF);
        end
        dv = 1'b0;
        // Strobe one cycle before the swap, a second strobe right after it
        rd_addr = 6'd16; rd_strobe = 1'b1;
        tick();
        rd_addr = 6'd17; vs = 1'b1;
        tick();
        rd_strobe = 1'b0; vs = 1'b0;
        check("swap_read_ack", 32'(ack), 32'd1);
        check("swap_read_hist", 32'(hist), 32'd100);
        check("swap_read_hist_c4", 32'(hist4), 32'd15);
        tick();
        check("second_strobe_no_ack", 32'(ack), 32'd0);
        tick();
        check("second_strobe_no_ack_late", 32'(ack), 32'd0);
        check("hist_held", 32'(hist), 32'd100);
        check("fd_cnt_f2", 32'(fd_cnt), 32'd2);
        check("sat_f2", 32'(sat), 32'd0);
        check("sat4_f2", 32'(sat4), 32'd1);
        do_read(6'd31);
        check("f2_bin31", 32'(hist), 32'd300);
        do_read(6'd2);
        check("f2_bin2", 32'(hist), 32'd100);
        check("f2_bin2_c4", 32'(hist4), 32'd15);
        do_read(6'd16);
        check("f2_bin16_cleared", 32'(hist), 32'd0);
        repeat (70) tick();

        // Frame 3: 5 pixels in bin 32, last one right before the vs edge
        for (int i = 0; i < 5; i++) begin
            pix(8'h80, 8'h80, 8'h80);
        end
        dv = 1'b0; vs = 1'b1;
        tick();
        vs = 1'b0;
        repeat (5) tick();
        check("sat4_f3_cleared", 32'(sat4), 32'd0);
        check("sat_f3", 32'(sat), 32'd0);
        check("lost_sticky", 32'(lost), 32'd1);
        check("bv4_f3", 32'(bv4), 32'd1);
        check("fd_cnt_f3", 32'(fd_cnt), 32'd3);
        check("fd4_cnt_f3", 32'(fd4_cnt), 32'd3);
        do_read(6'd32);
        check("f3_bin32", 32'(hist), 32'd5);
        check("f3_bin32_c4", 32'(hist4), 32'd5);
        do_read(6'd16);
        check("f3_bin16_cleared", 32'(hist), 32'd0);
        do_read(6'd31);
        check("f3_bin31", 32'(hist), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_hist_pp.md
Name: video_hist_pp

Overview:
- Parametrised, frame-synchronous histogram unit for the HDMI video path.
- Successor to the fixed single-bin histogram readout in the FIR pipeline. Adds configurable bin count, counter width and channel/luma mode selection.
- Uses ping-pong banks so software reads a completed frame while the next frame accumulates.
- Sits in the pixel clock domain beside the filter; readout uses the existing strobe/ack register handshake.

Parameters:
- DATA_W, 8: colour component width.
- BIN_BITS, 6: log2 of the bin count (2^BIN_BITS bins); must be ≤ DATA_W.
- CNT_W, 16: bin counter width; counters saturate.
- VS_ACT_HIGH, 1: 1 = vs_i active high; 0 = active low.

Ports:
- clk, input, 1: pixel clock; all logic is synchronous to it.
- rst_n, input, 1: synchronous, active-low reset.
- mode_i, input, 2: source select. 0 = red, 1 = green, 2 = blue, 3 = luma.
- red_i, input, DATA_W: pixel red.
- green_i, input, DATA_W: pixel green.
- blue_i, input, DATA_W: pixel blue.
- dv_i, input, 1: pixel valid.
- vs_i, input, 1: vertical sync.
- rd_strobe_i, input, 1: read request, one-cycle pulse.
- rd_addr_i, input, BIN_BITS: bin index to read.
- rd_ack_o, output, 1: read data valid, one-cycle pulse.
- hist_bin_o, output, CNT_W: read data.
- frame_done_o, output, 1: one-cycle pulse on bank swap.
- bank_valid_o, output, 1: a completed frame is available.
- sat_o, output, 1: some bin saturated in the last completed frame.
- lost_o, output, 1: sticky; a pixel arrived during CLEAR.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All outputs 0; state IDLE; write bank = 0.
  - Bank RAM contents are not reset; CLEAR handles them.
- Frame start:
  - Defined as the active edge of vs_i after polarity correction, detected with a 1-cycle registered compare.
  - mode_i is latched at frame start only; mid-frame changes take effect next frame.
- Bin value:
  - Modes 0–2: the selected component.
  - Mode 3: luma = (R + 2G + B) >> 2, computed at DATA_W+2 bits, result DATA_W bits.
  - bin = value[DATA_W-1 -: BIN_BITS].
- State machine:
  - IDLE → CLEAR on first frame start. No swap, no frame_done_o.
  - CLEAR: writes zero to bins 0 … 2^BIN_BITS−1 of the write bank, one per cycle. Then → ACCUM.
  - ACCUM: each dv_i = 1 cycle increments the pixel's bin.
  - ACCUM → CLEAR on frame start. In that same cycle:
    - write bank toggles; the previous write bank becomes the read bank;
    - frame_done_o pulses 1 cycle;
    - bank_valid_o goes 1 and stays 1 until reset;
    - sat_o is loaded from the frame's saturation flag; the flag is then cleared.
  - Frame start during CLEAR: ignored. Clearing continues; no swap.
- Accumulation pipeline (3 stages: bin compute/register, RAM read, increment/write):
  - One pixel per cycle, sustained.
  - Back-to-back hits on the same bin, and hits 2 apart, forward the in-flight count, so results are exact.
  - Increment at 2^CNT_W−1 holds the value and sets the saturation flag.
  - The pipeline drains fully before the swap takes effect. The last pixels (dv up to the cycle before the frame-start edge) count in the old frame.
- Pixels with dv_i = 1 during CLEAR or IDLE are not counted. During CLEAR they also set lost_o (sticky until reset).
- Readout:
  - The read bank is latched at rd_strobe_i.
  - rd_ack_o pulses exactly 2 cycles after the strobe; hist_bin_o is valid in that cycle and holds until the next ack.
  - A strobe while a read is in flight is ignored (no extra ack).
  - A swap between strobe and ack does not alter the returned data.
  - If bank_valid_o = 0, the read returns 0 with the normal ack timing.
- RAM: two banks of 2^BIN_BITS × CNT_W each, simple dual-port, inferred.

Test Plan:
- Reset, then a read of bin 5 → rd_ack_o at strobe+2, hist_bin_o = 0, bank_valid_o = 0, frame_done_o never pulses on the first vs.
- Frame 1: 100 pixels with mode 0, red = 0x40 (BIN_BITS 6 → bin 16); second vs → frame_done_o 1 pulse; read bin 16 = 100, bin 17 = 0.
- Mode 3, pixels R = 0xFF, G = 0x00, B = 0xFF → luma 0x7F → bin 31. Alternate bins 31/31/2/31 back-to-back for 400 pixels; read returns exact counts of 300 and 100 (forwarding check).
- CNT_W = 4 build: 20 pixels in one bin → read = 15, sat_o = 1 after the swap. Next frame without overflow → sat_o = 0.
- dv_i = 1 asserted 3 cycles after vs edge (during CLEAR) → lost_o = 1; those pixels are absent from the counts.
- Strobe issued 1 cycle before a swap → returns the old read-bank value. Second strobe 1 cycle after the first → ignored, single ack.
